// File: rtl/window_sequencer.sv
// Pops one feature-map row from the buffer FIFO and presents stride-1
// sliding windows of kernel_size pixels to the PE row over valid/ready.
// Ports: clk/rst (async, active-high); start, kernel_size, row_len (row request);
//   fifo_rd_en, fifo_rdata, fifo_empty (FIFO read side, 1-cycle read latency);
//   win_valid, win_ready, win_data, win_last (window stream to the PE row);
//   busy, done, err (status).
module window_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_K      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [7:0]                  kernel_size,
  input  logic [7:0]                  row_len,
  output logic                        fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]       fifo_rdata,
  input  logic                        fifo_empty,
  output logic                        win_valid,
  input  logic                        win_ready,
  output logic [MAX_K*DATA_WIDTH-1:0] win_data,
  output logic                        win_last,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam logic [7:0] KMAX = 8'(MAX_K);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } state_t;

  state_t state, state_nx;

  logic [7:0] k_r;
  logic [7:0] l_r;
  logic [7:0] rd_cnt;
  logic [7:0] fill_cnt;
  logic [7:0] win_cnt;
  logic       pend;
  logic       start_ok;
  logic       xfer;
  logic       last_xfer;

  logic [DATA_WIDTH-1:0] sh    [MAX_K];
  logic [DATA_WIDTH-1:0] sh_nx [MAX_K];

  assign start_ok  = start && (kernel_size != 8'd0) &&
                     (kernel_size <= KMAX) && (kernel_size <= row_len);
  assign xfer      = win_valid && win_ready;
  assign last_xfer = xfer && (win_cnt == 8'd1);
  // win_cnt only moves on a transfer, so this stays stable while held
  assign win_last  = win_valid && (win_cnt == 8'd1);
  assign busy      = (state != IDLE);

  // Shift the returned pixel in at lane k-1; lanes at or above k read 0
  always_comb begin
    for (int i = 0; i < MAX_K; i++) begin
      sh_nx[i] = '0;
      if (i + 1 < int'(k_r)) begin
        sh_nx[i] = sh[(i + 1) % MAX_K];
      end else if (i + 1 == int'(k_r)) begin
        sh_nx[i] = fifo_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    fifo_rd_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          state_nx = (kernel_size == 8'd1) ? STREAM : FILL;
        end
      end
      FILL: begin
        fifo_rd_en = !fifo_empty && !pend &&
                     (rd_cnt < k_r - 8'd1);
        if (pend && fill_cnt == 8'd1) begin
          state_nx = STREAM;
        end
      end
      STREAM: begin
        // a new read only once the held window leaves this cycle
        fifo_rd_en = !fifo_empty && !pend &&
                     (!win_valid || win_ready) &&
                     (rd_cnt < l_r);
        if (last_xfer) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_r       <= '0;
      l_r       <= '0;
      rd_cnt    <= '0;
      fill_cnt  <= '0;
      win_cnt   <= '0;
      pend      <= 1'b0;
      win_valid <= 1'b0;
      win_data  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < MAX_K; i++) begin
        sh[i] <= '0;
      end
    end else begin
      pend <= fifo_rd_en;
      done <= last_xfer;
      err  <= (state == IDLE) && start && !start_ok;
      if (fifo_rd_en) begin
        rd_cnt <= rd_cnt + 8'd1;
      end
      if (state == IDLE && start_ok) begin
        k_r      <= kernel_size;
        l_r      <= row_len;
        rd_cnt   <= '0;
        fill_cnt <= kernel_size - 8'd1;
        win_cnt  <= row_len - kernel_size + 8'd1;
        for (int i = 0; i < MAX_K; i++) begin
          sh[i] <= '0;
        end
      end
      if (xfer) begin
        win_valid <= 1'b0;
        win_cnt   <= win_cnt - 8'd1;
      end
      if (pend) begin
        for (int i = 0; i < MAX_K; i++) begin
          sh[i] <= sh_nx[i];
        end
        if (state == FILL) begin
          fill_cnt <= fill_cnt - 8'd1;
        end else begin
          for (int i = 0; i < MAX_K; i++) begin
            win_data[i*DATA_WIDTH +: DATA_WIDTH] <= sh_nx[i];
          end
          win_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_sequencer.sv
// Scoreboard bench for window_sequencer: FIFO model, random ready/empty,
// reference windows computed directly from the pixel list.
module tb_window_sequencer;

  localparam int DW = 16;
  localparam int MK = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    kernel_size = '0;
  logic [7:0]    row_len = '0;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_empty;
  logic          win_valid;
  logic          win_ready = 1'b1;
  logic [MK*DW-1:0] win_data;
  logic          win_last;
  logic          busy;
  logic          done;
  logic          err;

  window_sequencer #(.DATA_WIDTH(DW), .MAX_K(MK)) dut (
    .clk(clk), .rst(rst), .start(start),
    .kernel_size(kernel_size), .row_len(row_len),
    .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty), .win_valid(win_valid),
    .win_ready(win_ready), .win_data(win_data),
    .win_last(win_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MK*DW-1:0] data;
    logic             last;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic fail_t(input string nm, input logic [63:0] got,
                        input logic [63:0] exp);
    fails++;
    $display("FAIL %s got=%h expected=%h", nm, got, exp);
  endtask

  // FIFO model: one-cycle read latency, flushed by reset
  logic [DW-1:0] mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic hold_empty = 1'b0;
  assign fifo_empty = (rd_ptr == wr_ptr) || hold_empty;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= wr_ptr;
      fifo_rdata <= '0;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_rdata <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  int ready_mode = 0;
  int empty_mode = 0;
  int xfer_cnt = 0;
  int row_base = 0;
  int stall_c = 0;
  int hold_c = 0;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: win_ready = ($urandom_range(0, 2) != 0);
      2: begin
        if (xfer_cnt == 1 && stall_c < 10) begin
          win_ready = 1'b0;
          stall_c++;
        end else begin
          win_ready = 1'b1;
        end
      end
      default: win_ready = 1'b1;
    endcase
    case (empty_mode)
      1: hold_empty = ($urandom_range(0, 3) == 0);
      2: begin
        if (rd_ptr - row_base == 2 && hold_c < 8) begin
          hold_empty = 1'b1;
          hold_c++;
        end else begin
          hold_empty = 1'b0;
        end
      end
      default: hold_empty = 1'b0;
    endcase
  end

  // Monitor
  logic held = 1'b0;
  logic exp_done = 1'b0;
  logic [MK*DW-1:0] h_data;
  logic h_last;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 1'b0;
      exp_done = 1'b0;
    end else begin
      if (fifo_rd_en && fifo_empty)
        fail_t("rd_on_empty", 64'(fifo_rd_en), 64'd0);
      if (win_valid && !win_ready && fifo_rd_en)
        fail_t("rd_while_held", 64'(fifo_rd_en), 64'd0);
      if (held) begin
        tests++;
        if (!win_valid || win_data != h_data || win_last != h_last)
          fail_t("hold_stable", win_data, h_data);
      end
      if (exp_done) begin
        tests++;
        if (!done || win_valid || busy)
          fail_t("done_pulse", {61'd0, done, win_valid, busy}, 64'h4);
      end else if (done) begin
        fail_t("spurious_done", 64'(done), 64'd0);
      end
      exp_done = 1'b0;
      held = win_valid && !win_ready;
      h_data = win_data;
      h_last = win_last;
      if (win_valid && win_ready) begin
        tests++;
        xfer_cnt++;
        if (sb.size() == 0) begin
          fail_t("unexpected_window", win_data, 64'd0);
        end else begin
          e = sb.pop_front();
          if (win_data != e.data)
            fail_t("window_data", win_data, e.data);
          if (win_last != e.last)
            fail_t("window_last", 64'(win_last), 64'(e.last));
          if (e.last) exp_done = 1'b1;
        end
      end
    end
  end

  int pix[256];

  // Push pixels, queue the reference windows, pulse start
  task automatic start_row(input int k, input int l, input bit fast);
    exp_t e;
    row_base = wr_ptr;
    for (int i = 0; i < l; i++) begin
      mem[wr_ptr] = DW'(pix[i]);
      wr_ptr++;
    end
    for (int j = 0; j <= l - k; j++) begin
      e.data = '0;
      for (int i = 0; i < k; i++)
        e.data[i*DW +: DW] = DW'(pix[j+i]);
      e.last = (j == l - k);
      sb.push_back(e);
    end
    xfer_cnt = 0;
    stall_c = 0;
    hold_c = 0;
    if (!fast) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    kernel_size = 8'(k);
    row_len = 8'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (fast) begin
      @(negedge clk);
      tests++;
      if (!busy) fail_t("start_in_done_cycle", 64'(busy), 64'd1);
    end
  endtask

  task automatic wait_row();
    bit got = 0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    tests++;
    if (!got) begin
      fail_t("row_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end else if (sb.size() != 0) begin
      fail_t("row_leftover", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic bad_start(input int k, input int l);
    @(posedge clk);
    #1;
    start = 1'b1;
    kernel_size = 8'(k);
    row_len = 8'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    tests++;
    if (!err || busy)
      fail_t("err_pulse", {62'd0, err, busy}, 64'h2);
    @(negedge clk);
    tests++;
    if (err || busy || fifo_rd_en)
      fail_t("err_after", {61'd0, err, busy, fifo_rd_en}, 64'h0);
  endtask

  initial begin
    int k;
    int l;
    bit hit;
    repeat (3) @(negedge clk);
    tests++;
    if (fifo_rd_en || win_valid || win_data != '0 || win_last ||
        busy || done || err)
      fail_t("reset_state", win_data, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) pix[i] = i + 1;
    start_row(3, 6, 0);
    wait_row();

    for (int i = 0; i < 4; i++) pix[i] = 10 + i;
    start_row(1, 4, 1);
    wait_row();

    for (int i = 0; i < 4; i++) pix[i] = 16'ha000 + i;
    start_row(4, 4, 1);
    wait_row();

    bad_start(5, 6);
    bad_start(0, 4);
    bad_start(5, 3);
    bad_start(4, 3);

    for (int i = 0; i < 5; i++) pix[i] = 100 + i;
    ready_mode = 2;
    start_row(2, 5, 0);
    wait_row();
    ready_mode = 0;

    for (int i = 0; i < 5; i++) pix[i] = i + 1;
    empty_mode = 2;
    start_row(3, 5, 0);
    wait_row();
    empty_mode = 0;

    for (int i = 0; i < 5; i++) pix[i] = 200 + i;
    start_row(2, 5, 0);
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (xfer_cnt >= 1 && fifo_rd_en) hit = 1;
    end
    tests++;
    if (!hit) fail_t("reset_setup_timeout", 64'(xfer_cnt), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (fifo_rd_en || win_valid || win_last || busy || done || err)
      fail_t("async_reset",
             {58'd0, fifo_rd_en, win_valid, win_last, busy, done, err},
             64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) pix[i] = 16'h7700 + i;
    start_row(2, 3, 0);
    wait_row();

    ready_mode = 1;
    empty_mode = 1;
    for (int r = 0; r < 10; r++) begin
      k = $urandom_range(1, MK);
      l = $urandom_range(k, 12);
      for (int i = 0; i < l; i++) pix[i] = int'($urandom_range(0, 65535));
      start_row(k, l, 1);
      wait_row();
    end
    ready_mode = 0;
    empty_mode = 0;
    bad_start(MK + 1 + $urandom_range(0, 3), 10);

    for (int i = 0; i < 255; i++) pix[i] = i * 3;
    start_row(1, 255, 0);
    wait_row();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
